// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer: paced ADC start/capture sequencer with a done-strobe synchroniser,
// a show-ahead result FIFO and sticky overflow/timeout flags.
module adc_sample_sequencer #(
  parameter int FIFO_AW     = 3,
  parameter int START_WIDTH = 4,
  parameter int TIMEOUT     = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_in,
  input  logic               trigger_in,
  input  logic [15:0]        period_in,
  input  logic [15:0]        result_in,
  input  logic               conversion_finished_in,
  output logic               start_conversion_out,
  output logic               busy_out,
  output logic [15:0]        rd_data_out,
  output logic               rd_valid_out,
  input  logic               rd_ready_in,
  output logic [FIFO_AW:0]   level_out,
  output logic               overflow_out,
  output logic               timeout_out,
  input  logic               clear_flags_in
);
  localparam int SW_W = $clog2(START_WIDTH + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [SW_W-1:0] SW_LOAD = SW_W'(START_WIDTH);
  localparam logic [SW_W-1:0] SW_ONE  = SW_W'(1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, HOLDOFF} state_t;

  state_t            state_q, state_d;
  logic [SW_W-1:0]   scnt_q, scnt_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;
  logic [15:0]       hcnt_q, hcnt_d;
  logic              paced_q, paced_d;
  logic              start_q, start_d;
  logic              sync1_q, sync2_q, dly_q;
  logic [FIFO_AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic              ovf_q, ovf_d, tmo_q, tmo_d;
  logic [15:0]       mem_q [2**FIFO_AW];
  logic              done_pulse, push_req, tmo_set, push, pop, full, empty;

  assign done_pulse = sync2_q & ~dly_q;

  // paced_q remembers whether the running conversion belongs to enable-driven pacing,
  // so that dropping enable aborts only a paced holdoff, not a trigger's holdoff
  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    tcnt_d   = tcnt_q;
    hcnt_d   = hcnt_q;
    paced_d  = paced_q;
    start_d  = start_q;
    push_req = 1'b0;
    tmo_set  = 1'b0;
    case (state_q)
      IDLE: if (enable_in || trigger_in) begin
        state_d = START;
        scnt_d  = SW_LOAD;
        start_d = 1'b1;
        paced_d = enable_in;
      end
      START: if (scnt_q == SW_ONE) begin
        state_d = WAIT_DONE;
        start_d = 1'b0;
        tcnt_d  = '0;
      end else scnt_d = scnt_q - 1'b1;
      WAIT_DONE: if (done_pulse) begin
        push_req = 1'b1;
        state_d  = HOLDOFF;
        hcnt_d   = period_in;
      end else if (tcnt_q == TO_LAST) begin
        tmo_set = 1'b1;
        state_d = HOLDOFF;
        hcnt_d  = period_in;
      end else tcnt_d = tcnt_q + 1'b1;
      HOLDOFF: if (paced_q && !enable_in) state_d = IDLE;
      else if (hcnt_q == '0) begin
        state_d = enable_in ? START : IDLE;
        scnt_d  = SW_LOAD;
        start_d = enable_in;
        paced_d = enable_in;
      end else hcnt_d = hcnt_q - 1'b1;
      default: state_d = IDLE;
    endcase
  end

  assign level_out    = wr_q - rd_q;
  assign full         = level_out[FIFO_AW];
  assign empty        = level_out == '0;
  assign pop          = ~empty & rd_ready_in;
  assign push         = push_req & (~full | pop);
  assign wr_d         = push ? wr_q + 1'b1 : wr_q;
  assign rd_d         = pop ? rd_q + 1'b1 : rd_q;
  assign ovf_d        = (ovf_q & ~clear_flags_in) | (push_req & full & ~pop);
  assign tmo_d        = (tmo_q & ~clear_flags_in) | tmo_set;
  assign rd_valid_out = ~empty;
  assign rd_data_out  = empty ? '0 : mem_q[rd_q[FIFO_AW-1:0]];
  assign busy_out     = state_q != IDLE;
  assign start_conversion_out = start_q;
  assign overflow_out = ovf_q;
  assign timeout_out  = tmo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      tcnt_q  <= '0;
      hcnt_q  <= '0;
      paced_q <= 1'b0;
      start_q <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      tcnt_q  <= tcnt_d;
      hcnt_q  <= hcnt_d;
      paced_q <= paced_d;
      start_q <= start_d;
      sync1_q <= conversion_finished_in;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end

  // storage needs no reset: the read port is forced to zero while empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[FIFO_AW-1:0]] <= result_in;
  end
endmodule

// File: tb/tb_adc_sample_sequencer.sv
// tb_adc_sample_sequencer: scenario tasks with an ADC model, a read logger and
// expectations derived from the conversion timing rules.
module tb_adc_sample_sequencer;
  localparam int AW = 3, SW = 4, TO = 1023, DEPTH = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic enable_in = 1'b0, trigger_in = 1'b0, conversion_finished_in = 1'b0;
  logic rd_ready_in = 1'b0, clear_flags_in = 1'b0;
  logic [15:0] period_in = '0, result_in = '0;
  logic start_conversion_out, busy_out, rd_valid_out, overflow_out, timeout_out;
  logic [15:0] rd_data_out;
  logic [AW:0] level_out;

  int cyc = 0, n_checks = 0, n_fails = 0;
  int adc_delay = 6, adc_mode = 0, m_d;
  bit rand_dly = 1'b0;
  logic [15:0] adc_fixed = '0, seq_v = '0, m_v;
  int starts[$], dlys[$];
  logic [15:0] produced[$], rd_log[$], expv[$];

  adc_sample_sequencer #(.FIFO_AW(AW), .START_WIDTH(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .enable_in(enable_in), .trigger_in(trigger_in),
    .period_in(period_in), .result_in(result_in),
    .conversion_finished_in(conversion_finished_in),
    .start_conversion_out(start_conversion_out), .busy_out(busy_out),
    .rd_data_out(rd_data_out), .rd_valid_out(rd_valid_out), .rd_ready_in(rd_ready_in),
    .level_out(level_out), .overflow_out(overflow_out), .timeout_out(timeout_out),
    .clear_flags_in(clear_flags_in)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ADC model: finishes d edges after each start with a value from the chosen source
  initial forever begin
    @(posedge start_conversion_out);
    starts.push_back(cyc);
    m_d = rand_dly ? int'($urandom_range(12, 4)) : adc_delay;
    dlys.push_back(m_d);
    if (m_d >= 0) begin
      m_v = (adc_mode == 1) ? seq_v : (adc_mode == 2) ? adc_fixed : 16'($urandom);
      if (adc_mode == 1) seq_v = seq_v + 16'd1;
      repeat (m_d) @(posedge clk);
      #3;
      result_in = m_v;
      conversion_finished_in = 1'b1;
      produced.push_back(m_v);
      repeat (3) @(posedge clk);
      #3;
      conversion_finished_in = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && rd_ready_in && rd_valid_out) rd_log.push_back(rd_data_out);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    starts.delete();
    dlys.delete();
    produced.delete();
    rd_log.delete();
    expv.delete();
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    for (int i = 0; i < lim && busy_out; i++) tick();
    ok = !busy_out;
  endtask

  task automatic wait_valid(input int lim, output bit ok);
    for (int i = 0; i < lim && !rd_valid_out; i++) tick();
    ok = rd_valid_out;
  endtask

  task automatic drain(input int lim, output bit ok);
    rd_ready_in = 1'b1;
    for (int i = 0; i < lim && rd_valid_out; i++) tick();
    ok = !rd_valid_out;
    rd_ready_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({start_conversion_out, busy_out, rd_valid_out, overflow_out, timeout_out} !== 5'b0) begin
      n_fails++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {start_conversion_out, busy_out, rd_valid_out, overflow_out, timeout_out});
    end
    n_checks++;
    if (level_out !== '0 || rd_data_out !== 16'h0) begin
      n_fails++;
      $display("FAIL reset_fifo: level %0d data %h expected 0 0000", level_out, rd_data_out);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_trigger();
    int s, hi = 0, t_valid = -1, t_idle = -1;
    bit ok;
    clear_logs();
    adc_mode = 2; adc_fixed = 16'hA5C3; adc_delay = 10; rand_dly = 1'b0; period_in = 16'd8;
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    s = cyc;
    n_checks++;
    if (busy_out !== 1'b1) begin
      n_fails++;
      $display("FAIL single_busy: got %b expected 1", busy_out);
    end
    for (int i = 0; i < 40; i++) begin
      if (start_conversion_out) hi++;
      if (rd_valid_out && t_valid < 0) t_valid = cyc;
      if (!busy_out && t_idle < 0) t_idle = cyc;
      tick();
    end
    n_checks++;
    if (hi != SW) begin
      n_fails++;
      $display("FAIL single_start_width: got %0d cycles expected %0d", hi, SW);
    end
    // ADC raises just after edge s+d; the push lands two edges after it is first sampled
    n_checks++;
    if (t_valid != s + 10 + 3) begin
      n_fails++;
      $display("FAIL single_capture_time: got %0d expected %0d", t_valid, s + 13);
    end
    n_checks++;
    if (t_idle != s + 13 + 8 + 1) begin
      n_fails++;
      $display("FAIL single_idle_time: got %0d expected %0d", t_idle, s + 22);
    end
    n_checks++;
    if (rd_data_out !== 16'hA5C3 || level_out !== 4'd1) begin
      n_fails++;
      $display("FAIL single_result: data %h level %0d expected a5c3 1", rd_data_out, level_out);
    end
    drain(4, ok);
    n_checks++;
    if (!ok || rd_log.size() != 1 || level_out !== 4'd0) begin
      n_fails++;
      $display("FAIL single_pop: ok %0b log %0d level %0d expected 1 1 0", ok, rd_log.size(), level_out);
    end
  endtask

  task automatic test_paced();
    bit ok;
    clear_logs();
    adc_mode = 1; seq_v = '0; rand_dly = 1'b1; period_in = 16'd20;
    rd_ready_in = 1'b1;
    enable_in = 1'b1;
    for (int i = 0; i < 1000 && starts.size() < 8; i++) tick();
    enable_in = 1'b0;
    n_checks++;
    if (starts.size() < 8) begin
      n_fails++;
      $display("FAIL paced_starts: got %0d starts expected 8", starts.size());
    end
    wait_idle(100, ok);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL paced_idle: busy %b expected 0", busy_out);
    end
    repeat (3) tick();
    rd_ready_in = 1'b0;
    for (int i = 0; i + 1 < starts.size() && i < 7; i++) begin
      n_checks++;
      if (starts[i+1] - starts[i] != SW + (dlys[i] + 3 - SW) + 20 + 1) begin
        n_fails++;
        $display("FAIL paced_spacing[%0d]: got %0d expected %0d", i, starts[i+1] - starts[i],
                 SW + (dlys[i] + 3 - SW) + 21);
      end
    end
    n_checks++;
    if (produced.size() != 8 || rd_log.size() != 8) begin
      n_fails++;
      $display("FAIL paced_count: produced %0d read %0d expected 8 8", produced.size(), rd_log.size());
    end
    for (int i = 0; i < rd_log.size(); i++) begin
      n_checks++;
      if (rd_log[i] !== 16'(i)) begin
        n_fails++;
        $display("FAIL paced_data[%0d]: got %h expected %h", i, rd_log[i], 16'(i));
      end
    end
  endtask

  task automatic test_overflow();
    int s;
    bit ok;
    clear_logs();
    adc_mode = 0; rand_dly = 1'b0; adc_delay = 5; period_in = 16'($urandom_range(4, 0));
    enable_in = 1'b1;
    for (int i = 0; i < 600 && starts.size() < 10; i++) tick();
    enable_in = 1'b0;
    wait_idle(100, ok);
    n_checks++;
    if (!ok || produced.size() != 10) begin
      n_fails++;
      $display("FAIL ovf_conversions: idle %0b produced %0d expected 1 10", ok, produced.size());
    end
    n_checks++;
    if (level_out !== 4'd8 || overflow_out !== 1'b1) begin
      n_fails++;
      $display("FAIL ovf_full: level %0d ovf %b expected 8 1", level_out, overflow_out);
    end
    clear_flags_in = 1'b1;
    tick();
    clear_flags_in = 1'b0;
    n_checks++;
    if (overflow_out !== 1'b0) begin
      n_fails++;
      $display("FAIL ovf_clear: got %b expected 0", overflow_out);
    end
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    s = cyc;
    while (cyc < s + adc_delay + 2) tick();
    rd_ready_in = 1'b1;
    tick();
    rd_ready_in = 1'b0;
    n_checks++;
    if (level_out !== 4'd8 || overflow_out !== 1'b0) begin
      n_fails++;
      $display("FAIL ovf_push_pop_full: level %0d ovf %b expected 8 0", level_out, overflow_out);
    end
    wait_idle(50, ok);
    drain(20, ok);
    for (int i = 0; i < DEPTH && i < produced.size(); i++) expv.push_back(produced[i]);
    if (produced.size() > 10) expv.push_back(produced[10]);
    n_checks++;
    if (rd_log.size() != expv.size() || expv.size() != 9) begin
      n_fails++;
      $display("FAIL ovf_read_count: got %0d expected %0d", rd_log.size(), 9);
    end
    for (int i = 0; i < rd_log.size() && i < expv.size(); i++) begin
      n_checks++;
      if (rd_log[i] !== expv[i]) begin
        n_fails++;
        $display("FAIL ovf_data[%0d]: got %h expected %h", i, rd_log[i], expv[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int s = 0;
    bit ok;
    clear_logs();
    rand_dly = 1'b0; adc_delay = -1; adc_mode = 0; period_in = 16'd10;
    enable_in = 1'b1;
    tick();
    n_checks++;
    if (starts.size() != 1) begin
      n_fails++;
      $display("FAIL tmo_first_start: got %0d starts expected 1", starts.size());
    end else s = starts[0];
    while (cyc < s + SW + TO - 1) tick();
    n_checks++;
    if (timeout_out !== 1'b0) begin
      n_fails++;
      $display("FAIL tmo_early: got %b expected 0", timeout_out);
    end
    adc_delay = 6;
    clear_flags_in = 1'b1;
    tick();
    clear_flags_in = 1'b0;
    n_checks++;
    if (timeout_out !== 1'b1 || level_out !== 4'd0) begin
      n_fails++;
      $display("FAIL tmo_set: tmo %b level %0d expected 1 0", timeout_out, level_out);
    end
    for (int i = 0; i < 50 && starts.size() < 2; i++) tick();
    enable_in = 1'b0;
    n_checks++;
    if (starts.size() < 2 || starts[starts.size()-1] != s + SW + TO + 10 + 1) begin
      n_fails++;
      $display("FAIL tmo_next_start: got %0d starts last %0d expected start at %0d", starts.size(),
               starts.size() > 0 ? starts[starts.size()-1] : -1, s + SW + TO + 11);
    end
    wait_idle(60, ok);
    n_checks++;
    if (!ok || level_out !== 4'd1 || timeout_out !== 1'b1) begin
      n_fails++;
      $display("FAIL tmo_second: idle %0b level %0d tmo %b expected 1 1 1", ok, level_out, timeout_out);
    end
    clear_flags_in = 1'b1;
    tick();
    clear_flags_in = 1'b0;
    drain(4, ok);
    n_checks++;
    if (timeout_out !== 1'b0 || level_out !== 4'd0) begin
      n_fails++;
      $display("FAIL tmo_clear: tmo %b level %0d expected 0 0", timeout_out, level_out);
    end
  endtask

  task automatic test_spurious();
    bit ok;
    clear_logs();
    adc_mode = 2; adc_fixed = 16'($urandom); adc_delay = 5; period_in = 16'd30;
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    wait_valid(30, ok);
    repeat (2) tick();
    for (int k = 0; k < 3; k++) begin
      result_in = 16'($urandom);
      conversion_finished_in = 1'b1;
      repeat (3) tick();
      conversion_finished_in = 1'b0;
      repeat (2) tick();
    end
    n_checks++;
    if (busy_out !== 1'b1 || level_out !== 4'd1 || rd_data_out !== adc_fixed) begin
      n_fails++;
      $display("FAIL spur_holdoff: busy %b level %0d data %h expected 1 1 %h", busy_out, level_out,
               rd_data_out, adc_fixed);
    end
    wait_idle(40, ok);
    conversion_finished_in = 1'b1;
    repeat (3) tick();
    conversion_finished_in = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (!ok || level_out !== 4'd1 || overflow_out !== 1'b0 || timeout_out !== 1'b0) begin
      n_fails++;
      $display("FAIL spur_idle: idle %0b level %0d ovf %b tmo %b expected 1 1 0 0", ok, level_out,
               overflow_out, timeout_out);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    adc_delay = -1;
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    repeat (SW + 3) tick();
    n_checks++;
    if (busy_out !== 1'b1 || start_conversion_out !== 1'b0 || level_out !== 4'd1) begin
      n_fails++;
      $display("FAIL rst_pre: busy %b start %b level %0d expected 1 0 1", busy_out,
               start_conversion_out, level_out);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy_out, rd_valid_out, overflow_out, timeout_out} !== 4'b0 || level_out !== '0 ||
        rd_data_out !== 16'h0) begin
      n_fails++;
      $display("FAIL rst_wait_done: busy %b valid %b level %0d data %h expected all 0", busy_out,
               rd_valid_out, level_out, rd_data_out);
    end
    #2 rst_n = 1'b1;
    tick();
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    n_checks++;
    if (start_conversion_out !== 1'b1) begin
      n_fails++;
      $display("FAIL rst_restart: start %b expected 1", start_conversion_out);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (start_conversion_out !== 1'b0 || busy_out !== 1'b0) begin
      n_fails++;
      $display("FAIL rst_start_drop: start %b busy %b expected 0 0", start_conversion_out, busy_out);
    end
    #2 rst_n = 1'b1;
    tick();
    clear_logs();
    adc_delay = 7; adc_mode = 2; adc_fixed = 16'($urandom); period_in = 16'd3;
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    wait_valid(40, ok);
    n_checks++;
    if (!ok || rd_data_out !== adc_fixed || level_out !== 4'd1) begin
      n_fails++;
      $display("FAIL rst_fresh: valid %0b data %h level %0d expected 1 %h 1", ok, rd_data_out,
               level_out, adc_fixed);
    end
  endtask

  initial begin
    test_reset();
    test_single_trigger();
    test_paced();
    test_overflow();
    test_timeout();
    test_spurious();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/adc_sample_sequencer.md
# adc_sample_sequencer

Autonomous conversion sequencer and result buffer that sits directly downstream of the ADC top level. It issues `start_conversion` pulses at a programmable pacing interval and synchronises the asynchronous `conversion_finished` strobe into the system clock domain. It captures each 16-bit result into a small FIFO and presents the results on a valid/ready read port to the host-side register interface. Lost samples (FIFO overflow) and stalled conversions (timeout) are reported through sticky flags.

## Interface
- `FIFO_AW`, 3: FIFO address width; depth = 2**FIFO_AW entries of 16 bits.
- `START_WIDTH`, 4: cycles that `start_conversion_out` is held high per conversion (≥1).
- `TIMEOUT`, 1023: maximum cycles spent waiting for `conversion_finished_in` (≥1).
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `enable_in`  in  1  continuous (paced) conversion mode.
- `trigger_in`  in  1  single-cycle pulse requesting one conversion; honoured only in IDLE.
- `period_in`  in  16  holdoff cycles between a conversion's completion and the next start.
- `result_in`  in  16  ADC result; must be stable while `conversion_finished_in` is high.
- `conversion_finished_in`  in  1  ADC done strobe; asynchronous to `clk`.
- `start_conversion_out`  out  1  registered start request to the ADC.
- `busy_out`  out  1  high in every state except IDLE.
- `rd_data_out`  out  16  FIFO head (show-ahead).
- `rd_valid_out`  out  1  FIFO not empty.
- `rd_ready_in`  in  1  pop the FIFO head when high together with `rd_valid_out`.
- `level_out`  out  FIFO_AW+1  FIFO occupancy, 0..2**FIFO_AW.
- `overflow_out`  out  1  sticky: a result was dropped because the FIFO was full.
- `timeout_out`  out  1  sticky: a conversion timed out.
- `clear_flags_in`  in  1  clears both sticky flags.

## Operation
- Reset: state IDLE; FIFO empty; synchroniser flops 0; all outputs 0; `rd_data_out` 0.
- Finished synchroniser: 2-flop synchroniser followed by a delay flop; `done_pulse` = synced & ~delayed, i.e. the rising edge of the synced signal.
- FSM states: IDLE, START, WAIT_DONE, HOLDOFF.
- IDLE: when `enable_in` or `trigger_in` is high → START, with start counter loaded to START_WIDTH. `enable_in` has priority; both high counts as one start.
- START: `start_conversion_out` = 1 (registered) for exactly START_WIDTH cycles → WAIT_DONE, with the timeout counter cleared.
- WAIT_DONE:
  - On `done_pulse`: push `result_in` → HOLDOFF.
  - If TIMEOUT cycles elapse without `done_pulse`: set `timeout_out`, no push → HOLDOFF.
- HOLDOFF: `period_in` is sampled on entry; the block waits that many cycles.
  - At expiry: → START if `enable_in` is high, else → IDLE.
  - `period_in` = 0 leaves HOLDOFF on the next cycle.
- `enable_in` deasserted:
  - In START or WAIT_DONE: the current conversion completes (capture or timeout).
  - In HOLDOFF: → IDLE on the next cycle.
  - `trigger_in` outside IDLE is ignored.
- A `done_pulse` in any state other than WAIT_DONE is ignored: no push, no flag.
- FIFO:
  - Push when full and no pop in the same cycle: the data is dropped and `overflow_out` is set.
  - Push and pop in the same cycle while full: both succeed, `level_out` unchanged.
  - Pop when empty: no effect.
  - Pointers are FIFO_AW+1 bits and wrap naturally.
- Flags:
  - `clear_flags_in` clears both sticky flags.
  - A set event in the same cycle as a clear wins (the flag stays 1).

## Timing
- `enable_in` sampled high in IDLE at edge N → `start_conversion_out` high for cycles N+1..N+START_WIDTH; `busy_out` high from N+1.
- `conversion_finished_in` rising between edges K-1 and K → synced at K+1 → `done_pulse` at K+1 → push at edge K+2.
  - `rd_valid_out` and `level_out` update after edge K+2.
  - Capture latency is 2–3 clk cycles from the asynchronous edge.
- Pop takes effect at the edge where `rd_valid_out` & `rd_ready_in`; the new head appears the same cycle.
- Conversion-to-conversion spacing with enable held and an immediate done: START_WIDTH + (WAIT_DONE cycles) + `period_in` + 1.
- Reset assertion mid-conversion: all state clears immediately and `start_conversion_out` drops asynchronously.

## Test plan
- Single trigger: `trigger_in` pulse, ADC model returns 16'hA5C3 10 cycles after start → `start_conversion_out` high 4 cycles, one FIFO entry A5C3, `level_out`=1, FSM returns to IDLE after `period_in`.
- Paced mode: `enable_in`=1, `period_in`=20, ADC returns 0,1,2,…, reader always ready → results read in order with no gaps; start-to-start spacing matches the Timing formula exactly.
- Overflow: reader stalled, 10 conversions → `level_out`=8, first 8 values retained, `overflow_out`=1; `clear_flags_in` → 0; simultaneous push and pop at full keeps `level_out`=8.
- Timeout: ADC never finishes, TIMEOUT=1023 → `timeout_out` set 1023 cycles after WAIT_DONE entry, no push, next start issued after holdoff.
- Spurious done: `conversion_finished_in` toggles during HOLDOFF → no push, no flag.
- Reset mid-WAIT_DONE: assert `rst_n`=0 → all outputs 0 and FIFO empty immediately; after release a fresh trigger operates normally.
